// File: rtl/prog_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : prog_load_ctrl
// Description : Boot/run sequencer for the single-cycle MIPS core. Takes a
//               program as a valid/ready word stream and writes it into
//               instruction memory from address 0. Once the last word is in,
//               it releases the core, then halts the core when it fetches the
//               halt instruction or when the watchdog expires.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          clock; all state changes on the rising edge
//   reset_i        synchronous active-high reset
//   start_load_i   pulse: begin, restart or abort into a program load
//   ld_valid_i     load-stream word valid
//   ld_data_i      load-stream word
//   ld_last_i      final word of the program (only counts with ld_valid_i)
//   ld_ready_o     controller accepts a word this cycle
//   imem_we_o      instruction-memory write enable
//   imem_addr_o    instruction-memory write address
//   imem_wdata_o   instruction-memory write data
//   instr_i        instruction the core is fetching this cycle
//   cpu_reset_o    holds the core's PC and registers in reset
//   cpu_run_o      core may advance its PC this cycle
//   halted_o       core stopped (halt instruction or watchdog)
//   timeout_o      the halt was caused by the watchdog
//   overflow_o     load filled DEPTH words without seeing ld_last
//   word_count_o   words written in the last or current load
//   run_cycles_o   cycles spent in RUN since the core was released
// ============================================================================
module prog_load_ctrl #(
  parameter int          ADDR_W     = 9,
  parameter int          DEPTH      = 512,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter int          WDOG_W     = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_load_i,
  input  logic              ld_valid_i,
  input  logic [31:0]       ld_data_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  input  logic [31:0]       instr_i,
  output logic              cpu_reset_o,
  output logic              cpu_run_o,
  output logic              halted_o,
  output logic              timeout_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic [WDOG_W-1:0] run_cycles_o
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_BOOT = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  // Index of the last word that fits in memory; taking it without ld_last
  // means the program is too long.
  localparam int unsigned     LAST_IDX_I = DEPTH - 1;
  localparam logic [ADDR_W:0] LAST_IDX   = LAST_IDX_I[ADDR_W:0];
  localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic                overflow_q, overflow_d;
  logic                halted_q, halted_d;
  logic                timeout_q, timeout_d;
  logic [WDOG_W-1:0]   run_cycles_q, run_cycles_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ld_ready;
  logic                handshake;

  assign ld_ready  = (state_q == ST_LOAD);
  assign handshake = ld_valid_i & ld_ready;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      word_count_q <= '0;
      overflow_q   <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      run_cycles_q <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      overflow_q   <= overflow_d;
      halted_q     <= halted_d;
      timeout_q    <= timeout_d;
      run_cycles_q <= run_cycles_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    overflow_d   = overflow_q;
    halted_d     = halted_q;
    timeout_d    = timeout_q;
    run_cycles_d = run_cycles_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    if (start_load_i) begin
      // start_load wins in every state: it starts a fresh load from
      // address 0, aborts a running core, and drops any handshake offered
      // in the same cycle. The core is back in reset on the next cycle
      // because LOAD is not RUN.
      state_d      = ST_LOAD;
      word_count_d = '0;
      overflow_d   = 1'b0;
      halted_d     = 1'b0;
      timeout_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end

        ST_LOAD: begin
          if (handshake) begin
            we_d         = 1'b1;
            addr_d       = word_count_q[ADDR_W-1:0];
            wdata_d      = ld_data_i;
            word_count_d = word_count_q + 1'b1;
            if (ld_last_i) begin
              state_d = ST_BOOT;
            end else if (word_count_q == LAST_IDX) begin
              // The memory is full and the program has not ended. The
              // final word is still written, but the core is not released.
              overflow_d = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end

        ST_BOOT: begin
          // Lets the last registered write land before the core fetches.
          state_d      = ST_RUN;
          run_cycles_d = '0;
          halted_d     = 1'b0;
          timeout_d    = 1'b0;
        end

        ST_RUN: begin
          // The halt instruction is checked before the watchdog so a halt
          // fetched in the expiry cycle is not reported as a timeout.
          if (instr_i == HALT_INSTR) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else if (run_cycles_q == WDOG_MAX) begin
            state_d   = ST_HALT;
            halted_d  = 1'b1;
            timeout_d = 1'b1;
          end else begin
            run_cycles_d = run_cycles_q + 1'b1;
          end
        end

        ST_HALT: begin
          state_d = ST_HALT;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign ld_ready_o   = ld_ready;
  assign imem_we_o    = we_q;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign cpu_reset_o  = (state_q != ST_RUN);
  assign cpu_run_o    = (state_q == ST_RUN);
  assign halted_o     = halted_q;
  assign timeout_o    = timeout_q;
  assign overflow_o   = overflow_q;
  assign word_count_o = word_count_q;
  assign run_cycles_o = run_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_load_ctrl
// Description : Self-checking bench for prog_load_ctrl. Every accepted
//               load word pushes its expected {address, data} onto a
//               scoreboard queue. A negedge monitor pops one entry and
//               compares it on every instruction-memory write. Control and
//               status outputs are checked directly at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_load_ctrl;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int WDOG_W = 4;

  logic              clk;
  logic              reset;
  logic              start_load;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [31:0]       instr;
  logic              cpu_reset;
  logic              cpu_run;
  logic              halted;
  logic              timeout;
  logic              overflow;
  logic [ADDR_W:0]   word_count;
  logic [WDOG_W-1:0] run_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int exp_idx  = 0;
  logic [40:0] exp_q[$];

  prog_load_ctrl #(
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .HALT_INSTR(32'hFFFF_FFFF),
    .WDOG_W    (WDOG_W)
  ) u_dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .start_load_i(start_load),
    .ld_valid_i  (ld_valid),
    .ld_data_i   (ld_data),
    .ld_last_i   (ld_last),
    .ld_ready_o  (ld_ready),
    .imem_we_o   (imem_we),
    .imem_addr_o (imem_addr),
    .imem_wdata_o(imem_wdata),
    .instr_i     (instr),
    .cpu_reset_o (cpu_reset),
    .cpu_run_o   (cpu_run),
    .halted_o    (halted),
    .timeout_o   (timeout),
    .overflow_o  (overflow),
    .word_count_o(word_count),
    .run_cycles_o(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest accepted word.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("imem_write_unexpected", {23'd0, imem_addr, imem_wdata}, 64'd0);
      end else begin
        chk("imem_write", {23'd0, imem_addr, imem_wdata}, {23'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; start_load is seen on the next edge.
  task automatic pulse_start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
  endtask

  // Offers n words starting at base. With gaps, ld_valid is low every
  // other cycle. Returns just after the edge that took the last word.
  task automatic send_words(input int n, input logic [31:0] base,
                            input bit last_on_end, input bit gaps);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 4000) begin
      ld_valid = gaps ? ((cyc % 2) == 0) : 1'b1;
      ld_data  = base + sent;
      ld_last  = last_on_end && (sent == n - 1);
      @(negedge clk);
      if (ld_valid && ld_ready) begin
        exp_q.push_back({exp_idx[ADDR_W-1:0], ld_data});
        exp_idx++;
        sent++;
      end
      step();
      cyc++;
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("send_words_count", sent, n);
  endtask

  initial begin
    int cyc;
    reset      = 1'b1;
    start_load = 1'b0;
    ld_valid   = 1'b0;
    ld_data    = '0;
    ld_last    = 1'b0;
    instr      = '0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_ld_ready", ld_ready, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_word_count", word_count, 0);
    chk("rst_run_cycles", run_cycles, 0);
    step();
    reset = 1'b0;

    // Load four words, boot, release
    pulse_start();
    exp_idx = 0;
    send_words(4, 32'h2008_0005, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_boot_word_count", word_count, 4);
    chk("t1_boot_cpu_reset", cpu_reset, 1);
    chk("t1_boot_ld_ready", ld_ready, 0);
    chk("t1_boot_cpu_run", cpu_run, 0);
    step();
    @(negedge clk);
    chk("t1_run_cpu_reset", cpu_reset, 0);
    chk("t1_run_cpu_run", cpu_run, 1);
    chk("t1_run_cycles0", run_cycles, 0);

    // Halt instruction fetched in the cycle where run_cycles is 10
    cyc = 0;
    while (run_cycles !== 4'd10 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_reach_10", run_cycles, 10);
    instr = 32'hFFFF_FFFF;
    step();
    instr = '0;
    @(negedge clk);
    chk("t3_halted", halted, 1);
    chk("t3_timeout", timeout, 0);
    chk("t3_cpu_run", cpu_run, 0);
    chk("t3_cpu_reset", cpu_reset, 1);
    chk("t3_run_cycles", run_cycles, 10);
    repeat (3) @(negedge clk);
    chk("t3_run_cycles_frozen", run_cycles, 10);
    chk("t3_halted_held", halted, 1);

    // Reload from HALT with gapped valid
    step();
    pulse_start();
    @(negedge clk);
    chk("t2_halted_cleared", halted, 0);
    chk("t2_ld_ready", ld_ready, 1);
    step();
    exp_idx = 0;
    send_words(6, 32'hA000_0000, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_word_count", word_count, 6);
    step();

    // Watchdog: no halt instruction
    cyc = 0;
    while (halted !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    chk("t4_halted", halted, 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_run_cycles", run_cycles, 15);
    chk("t4_cpu_run", cpu_run, 0);

    // Abort a running core
    step();
    pulse_start();
    exp_idx = 0;
    send_words(2, 32'hB000_0000, 1'b1, 1'b0);
    repeat (3) step();
    @(negedge clk);
    chk("t6_running", cpu_run, 1);
    step();
    pulse_start();
    @(negedge clk);
    chk("t6_abort_cpu_reset", cpu_reset, 1);
    chk("t6_abort_cpu_run", cpu_run, 0);
    chk("t6_abort_ld_ready", ld_ready, 1);
    chk("t6_abort_word_count", word_count, 0);

    // ld_last without ld_valid is ignored
    ld_last = 1'b1;
    step();
    ld_last = 1'b0;
    @(negedge clk);
    chk("t6_last_no_valid_ready", ld_ready, 1);
    chk("t6_last_no_valid_count", word_count, 0);

    // Restart in LOAD drops the same-cycle handshake
    step();
    exp_idx = 0;
    send_words(1, 32'hC000_0000, 1'b0, 1'b0);
    start_load = 1'b1;
    ld_valid   = 1'b1;
    ld_data    = 32'hDEAD_BEEF;
    step();
    start_load = 1'b0;
    ld_valid   = 1'b0;
    @(negedge clk);
    chk("t6_restart_no_write", imem_we, 0);
    chk("t6_restart_word_count", word_count, 0);

    // Reset in the middle of a load
    step();
    exp_idx = 0;
    send_words(2, 32'hD000_0000, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("t6_rst_cpu_reset", cpu_reset, 1);
    chk("t6_rst_ld_ready", ld_ready, 0);
    chk("t6_rst_word_count", word_count, 0);
    chk("t6_rst_run_cycles", run_cycles, 0);
    chk("t6_rst_imem_we", imem_we, 0);
    step();
    reset = 1'b0;

    // Overflow: a full memory of words and no ld_last
    pulse_start();
    exp_idx = 0;
    send_words(DEPTH, 32'h1000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("t5_overflow", overflow, 1);
    chk("t5_ld_ready", ld_ready, 0);
    chk("t5_cpu_reset", cpu_reset, 1);
    chk("t5_word_count", word_count, DEPTH);
    repeat (3) step();
    @(negedge clk);
    chk("t5_overflow_sticky", overflow, 1);
    chk("t5_cpu_run_idle", cpu_run, 0);
    step();
    pulse_start();
    @(negedge clk);
    chk("t5_overflow_cleared", overflow, 0);

    repeat (2) step();
    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
